// File: rtl/kan_pkg.sv
// Shared types for the KAN inter-layer stream blocks:
// reader state encoding and the queue entry layout {last, data}.
package kan_pkg;

    localparam int DWIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REWIND,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

    typedef struct packed {
        logic                  last;
        logic [DWIDTH_DEF-1:0] data;
    } q_entry_t;

endpackage

// File: rtl/fifo_replay_reader_if.sv
// Valid/ready word stream carrying a last-of-pass tag.
interface fifo_replay_reader_if
    import kan_pkg::*;
#(
    parameter int DW = DWIDTH_DEF
);

    logic [DW-1:0] data;
    logic          last;
    logic          valid;
    logic          ready;

    modport master (output data, last, valid, input ready);
    modport slave  (input data, last, valid, output ready);

endinterface

// File: rtl/fifo_replay_reader_queue.sv
// First-word-fall-through synchronous queue of {last, data} entries
// with an occupancy count; shared by the stream blocks.
module stream_queue
    import kan_pkg::*;
#(
    parameter int DW     = DWIDTH_DEF,
    parameter int QDEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DW:0]                entry_i,
    output logic [$clog2(QDEPTH):0]    count_o,
    fifo_replay_reader_if.master       deq
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [DW:0]   mem_q [QDEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    assign deq.valid = (cnt_q != '0);
    assign deq.data  = mem_q[rd_q][DW-1:0];
    assign deq.last  = mem_q[rd_q][DW];
    assign pop       = deq.valid & deq.ready;
    assign count_o   = cnt_q;

    always_comb begin
        wr_d  = push_i ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= entry_i;
    end

    // Read credit upstream must make a push into a full queue impossible.
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push_i && cnt_q == CW'(QDEPTH))
    );

endmodule

// File: rtl/fifo_replay_reader.sv
// Read-side controller for the rewindable stream FIFO: replays its
// contents a run-time number of passes onto a valid/ready stream.
module fifo_replay_reader
    import kan_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int PWIDTH = 8,
    parameter int QDEPTH = 4
) (
    input  logic              iclk,
    input  logic              iresetn,
    input  logic              istart,
    input  logic [PWIDTH-1:0] ipasses,
    output logic              ofifo_read,
    output logic              ofifo_rrst,
    input  logic [DWIDTH-1:0] ififo_data,
    input  logic              ififo_end,
    output logic [DWIDTH-1:0] odata,
    output logic              ovalid,
    input  logic              iready,
    output logic              olast,
    output logic              olast_pass,
    output logic              obusy,
    output logic              odone
);

    localparam int CW = $clog2(QDEPTH) + 1;

    rd_state_e         state_q, state_d;
    logic [PWIDTH-1:0] pass_q, pass_d;
    logic [PWIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]        infl_q, infl_d;
    logic [CW-1:0]     occ;
    logic              capture;
    logic              credit;
    logic              more;
    logic              drained;

    fifo_replay_reader_if #(.DW(DWIDTH)) sq ();

    assign sq.ready = iready;

    stream_queue #(
        .DW     (DWIDTH),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i   (iclk),
        .rst_ni  (iresetn),
        .push_i  (capture),
        .entry_i ({ififo_end, ififo_data}),
        .count_o (occ),
        .deq     (sq)
    );

    // FIFO data lands one cycle after its read strobe.
    assign capture = (state_q == ST_STREAM) && (infl_q != '0);
    assign credit  = ({1'b0, occ} + (CW+1)'(infl_q)) < (CW+1)'(QDEPTH);
    assign more    = ((PWIDTH+1)'(pass_q) + (PWIDTH+1)'(1))
                     < (PWIDTH+1)'(cnt_q);
    assign drained = (occ == '0);

    always_ff @(posedge iclk) begin
        if (!iresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (istart)
                    state_d = (ipasses != '0) ? ST_REWIND : ST_DONE;
            end
            ST_REWIND: state_d = ST_STREAM;
            ST_STREAM: begin
                if (ififo_end && infl_q == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained) state_d = more ? ST_REWIND : ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ofifo_rrst = 1'b0;
        ofifo_read = 1'b0;
        odone      = 1'b0;
        obusy      = 1'b1;
        unique case (state_q)
            ST_IDLE:   obusy      = 1'b0;
            ST_REWIND: ofifo_rrst = 1'b1;
            ST_STREAM: ofifo_read = ~ififo_end & credit;
            ST_DONE:   odone      = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        pass_d = pass_q;
        cnt_d  = cnt_q;
        infl_d = infl_q + 2'(ofifo_read) - 2'(capture);
        if (state_q == ST_IDLE && istart) begin
            cnt_d  = ipasses;
            pass_d = '0;
        end
        if (state_q == ST_DRAIN && drained && more)
            pass_d = pass_q + PWIDTH'(1);
    end

    always_ff @(posedge iclk) begin
        if (!iresetn) begin
            pass_q <= '0;
            cnt_q  <= '0;
            infl_q <= '0;
        end else begin
            pass_q <= pass_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    assign ovalid     = sq.valid;
    assign odata      = ovalid ? sq.data : '0;
    assign olast      = ovalid & sq.last;
    // The pass index only moves once the queue is empty, so this is stable.
    assign olast_pass = ovalid & (pass_q == cnt_q - PWIDTH'(1));

endmodule

// File: tb/tb_fifo_replay_reader.sv
// Bench for fifo_replay_reader: FIFO model, replay scoreboard,
// directed scenarios with literal totals.
module tb_fifo_replay_reader;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int QD = 4;

    logic          iclk = 1'b0;
    logic          iresetn = 1'b0;
    logic          istart = 1'b0;
    logic          iready = 1'b1;
    logic [PW-1:0] ipasses = '0;
    logic          ofifo_read, ofifo_rrst, ififo_end;
    logic [DW-1:0] ififo_data, odata;
    logic          ovalid, olast, olast_pass, obusy, odone;

    fifo_replay_reader #(
        .DWIDTH (DW),
        .PWIDTH (PW),
        .QDEPTH (QD)
    ) dut (
        .iclk       (iclk),
        .iresetn    (iresetn),
        .istart     (istart),
        .ipasses    (ipasses),
        .ofifo_read (ofifo_read),
        .ofifo_rrst (ofifo_rrst),
        .ififo_data (ififo_data),
        .ififo_end  (ififo_end),
        .odata      (odata),
        .ovalid     (ovalid),
        .iready     (iready),
        .olast      (olast),
        .olast_pass (olast_pass),
        .obusy      (obusy),
        .odone      (odone)
    );

    fifo_replay_reader_if #(.DW(DW)) mon ();
    assign mon.data  = odata;
    assign mon.valid = ovalid;
    assign mon.last  = olast;
    assign mon.ready = iready;

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    // Rewindable FIFO model: registered read data, end = (rptr == wptr).
    logic [DW-1:0] fmem [16];
    logic [3:0]    rptr = '0;
    logic [3:0]    wptr = '0;
    logic [DW-1:0] rdata = '0;
    assign ififo_end  = (rptr == wptr);
    assign ififo_data = rdata;
    always @(posedge iclk) begin
        if (ofifo_rrst) rptr <= '0;
        else if (ofifo_read) begin
            rdata <= fmem[rptr];
            rptr  <= rptr + 4'd1;
        end
    end

    int rmode = 0;
    initial forever begin
        @(posedge iclk);
        #1;
        case (rmode)
            0:       iready = 1'b1;
            1:       iready = (cyc % 3 == 0);
            default: iready = 1'b0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          lp;
    } exp_t;

    exp_t expq[$];
    logic mbusy = 1'b0;
    int   n_xfer = 0, n_last = 0, n_lp = 0, n_rrst = 0, n_read = 0;
    int   n_done = 0, n_busy = 0;
    int   start_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
    logic [DW-1:0] first_data = '0;
    logic          got_first = 1'b0;

    // Scoreboard: expected words come from FIFO contents and pass count.
    initial begin : cmp
        exp_t          e;
        logic          acc;
        logic          stall;
        logic [DW+1:0] held;
        int            nw;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge iclk);
            if (!iresetn) begin
                expq.delete();
                mbusy = 1'b0;
                stall = 1'b0;
            end else begin
                chk("obusy", {31'd0, obusy}, {31'd0, mbusy});
                if (stall) begin
                    chk("stall_valid", {31'd0, ovalid}, 32'd1);
                    chk("stall_hold", {14'd0, olast, olast_pass, odata},
                        {14'd0, held});
                end
                stall = 1'b0;
                if (ovalid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (iready) begin
                        if (!got_first) begin
                            first_data = odata;
                            got_first  = 1'b1;
                        end
                        if (expq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL xfer_extra: got %0h expected none",
                                     odata);
                        end else begin
                            e = expq.pop_front();
                            chk("xfer", {14'd0, olast, olast_pass, odata},
                                {14'd0, e.l, e.lp, e.d});
                        end
                        n_xfer++;
                        n_last += int'(olast);
                        n_lp   += int'(olast_pass);
                    end else begin
                        stall = 1'b1;
                        held  = {olast, olast_pass, odata};
                    end
                end
                n_rrst += int'(ofifo_rrst);
                n_read += int'(ofifo_read);
                if (obusy) n_busy++;
                acc = istart && !mbusy;
                if (odone) begin
                    chk("done_drained", expq.size(), 32'd0);
                    mbusy = 1'b0;
                    n_done++;
                    done_cyc = cyc;
                end
                if (acc) begin
                    mbusy           = 1'b1;
                    start_cyc       = cyc;
                    first_valid_cyc = -1;
                    got_first       = 1'b0;
                    nw              = int'(wptr);
                    for (int p = 0; p < int'(ipasses); p++)
                        for (int w = 0; w < nw; w++) begin
                            e.d  = fmem[w];
                            e.l  = (w == nw - 1);
                            e.lp = (p == int'(ipasses) - 1);
                            expq.push_back(e);
                        end
                end
            end
        end
    end

    int b_xfer, b_last, b_lp, b_rrst, b_read, b_busy;

    task automatic snap();
        b_xfer = n_xfer; b_last = n_last; b_lp = n_lp;
        b_rrst = n_rrst; b_read = n_read; b_busy = n_busy;
    endtask

    task automatic load(int n);
        for (int i = 0; i < n; i++) fmem[i] = DW'(i + 1);
        wptr = 4'(n);
    endtask

    task automatic start(int p);
        @(posedge iclk); #1;
        istart  = 1'b1;
        ipasses = PW'(p);
        @(posedge iclk); #1;
        istart  = 1'b0;
    endtask

    task automatic wait_done(string name);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < 400) begin
            @(posedge iclk);
            k++;
        end
        chk({name, "_done"}, n_done - d0, 32'd1);
        repeat (2) @(posedge iclk);
    endtask

    task automatic wait_xfers(int n, string name);
        int k;
        k = 0;
        while (n_xfer - b_xfer < n && k < 400) begin
            @(posedge iclk);
            k++;
        end
        chk({name, "_reached"}, 32'(n_xfer - b_xfer >= n), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        chk("rst_outs", {26'd0, ovalid, olast, olast_pass, obusy, odone,
                         ofifo_read | ofifo_rrst}, 32'd0);
        chk("rst_odata", {16'd0, odata}, 32'd0);
        @(posedge iclk); #1;
        iresetn = 1'b1;

        // 5 words, 3 passes, always ready
        load(5); snap(); rmode = 0;
        start(3);
        wait_done("t1");
        chk("t1_xfers", n_xfer - b_xfer, 32'd15);
        chk("t1_lasts", n_last - b_last, 32'd3);
        chk("t1_lastpass", n_lp - b_lp, 32'd5);
        chk("t1_rrst", n_rrst - b_rrst, 32'd3);
        chk("t1_reads", n_read - b_read, 32'd15);
        chk("t1_latency", first_valid_cyc - start_cyc, 32'd4);

        // same load, ready 1-on/2-off
        snap(); rmode = 1;
        start(3);
        wait_done("t2");
        chk("t2_xfers", n_xfer - b_xfer, 32'd15);
        chk("t2_lasts", n_last - b_last, 32'd3);
        chk("t2_lastpass", n_lp - b_lp, 32'd5);
        chk("t2_reads", n_read - b_read, 32'd15);

        // empty FIFO, 2 passes
        load(0); snap(); rmode = 0;
        start(2);
        wait_done("t3");
        chk("t3_rrst", n_rrst - b_rrst, 32'd2);
        chk("t3_xfers", n_xfer - b_xfer, 32'd0);
        chk("t3_reads", n_read - b_read, 32'd0);

        // zero passes
        load(5); snap();
        start(0);
        wait_done("t4");
        chk("t4_rrst", n_rrst - b_rrst, 32'd0);
        chk("t4_reads", n_read - b_read, 32'd0);
        chk("t4_busy", n_busy - b_busy, 32'd1);
        chk("t4_done_at", done_cyc - start_cyc, 32'd1);

        // reset mid pass 2, then replay
        snap(); rmode = 1;
        start(3);
        wait_xfers(7, "t5");
        @(posedge iclk); #1;
        rmode   = 2;
        iready  = 1'b0;
        iresetn = 1'b0;
        @(posedge iclk); #1;
        iresetn = 1'b1;
        @(negedge iclk);
        chk("t5_ovalid", {31'd0, ovalid}, 32'd0);
        chk("t5_obusy", {31'd0, obusy}, 32'd0);
        rmode = 0;
        snap();
        start(1);
        wait_done("t5b");
        chk("t5_first", {16'd0, first_data}, 32'h0001);
        chk("t5_xfers", n_xfer - b_xfer, 32'd5);

        // istart during STREAM is ignored
        snap(); rmode = 0;
        start(2);
        wait_xfers(3, "t6");
        @(posedge iclk); #1;
        istart  = 1'b1;
        ipasses = PW'(7);
        @(posedge iclk); #1;
        istart  = 1'b0;
        wait_done("t6");
        chk("t6_xfers", n_xfer - b_xfer, 32'd10);
        chk("t6_rrst", n_rrst - b_rrst, 32'd2);
        chk("t6_lastpass", n_lp - b_lp, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
